// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder: operation encoding
// and the elaboration-time geometry helpers used to size and check the block chain.
package csa_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned csa_nblk(input int unsigned width, input int unsigned blk);
    return width / blk;
  endfunction

  function automatic int unsigned csa_bps(input int unsigned width, input int unsigned blk,
                                          input int unsigned stages);
    return csa_nblk(width, blk) / stages;
  endfunction

  function automatic bit csa_legal(input int unsigned width, input int unsigned blk,
                                   input int unsigned stages);
    if (width == 0 || blk == 0 || stages == 0) return 1'b0;
    if (width % blk != 0) return 1'b0;
    return (csa_nblk(width, blk) % stages) == 0;
  endfunction

endpackage

// File: rtl/csa_pipe_adder_if.sv
// Operand/result handshake bundle for csa_pipe_adder; the adder sits on the slave side.
interface csa_pipe_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_block.sv
// One carry-select block: two ripple-carry adders (carry-in 0 and 1) with the
// incoming carry choosing the sum, the carry out and the carry into the top bit.
module csa_block #(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  input  logic           c_i,
  output logic [BLK-1:0] sum_o,
  output logic           c_o,
  output logic           ctop_o
);

  logic [BLK-1:0] s0, s1;
  logic           co0, co1;
  logic           ct0, ct1;

  always_comb begin
    logic k0, k1;
    k0  = 1'b0;
    k1  = 1'b1;
    s0  = '0;
    s1  = '0;
    ct0 = 1'b0;
    ct1 = 1'b1;
    for (int unsigned i = 0; i < BLK; i++) begin
      ct0   = k0;
      ct1   = k1;
      s0[i] = a_i[i] ^ b_i[i] ^ k0;
      s1[i] = a_i[i] ^ b_i[i] ^ k1;
      k0    = (a_i[i] & b_i[i]) | (k0 & (a_i[i] ^ b_i[i]));
      k1    = (a_i[i] & b_i[i]) | (k1 & (a_i[i] ^ b_i[i]));
    end
    co0 = k0;
    co1 = k1;
  end

  assign sum_o  = c_i ? s1  : s0;
  assign c_o    = c_i ? co1 : co0;
  assign ctop_o = c_i ? ct1 : ct0;

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor: NBLK carry-select blocks split evenly
// over STAGES register stages, with valid/ready flow control on both sides.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLK    = 4,
  parameter int unsigned STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  csa_pipe_adder_if.slave bus
);

  localparam int unsigned NBLK = csa_nblk(WIDTH, BLK);
  localparam int unsigned BPS  = csa_bps(WIDTH, BLK, STAGES);

  if (!csa_legal(WIDTH, BLK, STAGES)) begin : g_bad_params
    $error("csa_pipe_adder: WIDTH must be a multiple of BLK and WIDTH/BLK a multiple of STAGES");
  end

  // aw_q holds finished sum bits below the stage boundary and untouched A bits above it
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] aw_q  [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q;

  logic             vld_s [STAGES];
  logic [WIDTH-1:0] aw_s  [STAGES];
  logic [WIDTH-1:0] b_s   [STAGES];
  logic             c_s   [STAGES];

  logic [WIDTH-1:0] aw_d  [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_d;
  logic [STAGES-1:0] rdy;

  logic [BLK-1:0]   bsum  [NBLK];
  logic             ctop  [NBLK];

  op_e op_w;
  assign op_w = op_e'(bus.sub);

  always_comb begin
    vld_s[0] = bus.in_valid;
    aw_s[0]  = bus.a;
    b_s[0]   = (op_w == OP_SUB) ? ~bus.b : bus.b;
    c_s[0]   = (op_w == OP_SUB) ? ~bus.cin : bus.cin;
    for (int unsigned k = 1; k < STAGES; k++) begin
      vld_s[k] = vld_q[k-1];
      aw_s[k]  = aw_q[k-1];
      b_s[k]   = b_q[k-1];
      c_s[k]   = c_q[k-1];
    end
  end

  always_comb begin
    logic r;
    r   = bus.out_ready;
    rdy = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      r      = !vld_q[k] || r;
      rdy[k] = r;
    end
  end

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    logic cin_w;
    logic cout_w;

    if (j % BPS == 0) begin : g_stage_first
      assign cin_w = c_s[j / BPS];
    end else begin : g_chain
      assign cin_w = g_blk[j-1].cout_w;
    end

    if (j % BPS == BPS - 1) begin : g_stage_last
      assign c_d[j / BPS] = cout_w;
    end

    csa_block #(.BLK(BLK)) u_blk (
      .a_i    (aw_s[j / BPS][j * BLK +: BLK]),
      .b_i    (b_s[j / BPS][j * BLK +: BLK]),
      .c_i    (cin_w),
      .sum_o  (bsum[j]),
      .c_o    (cout_w),
      .ctop_o (ctop[j])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      aw_d[k] = aw_s[k];
    end
    for (int unsigned j = 0; j < NBLK; j++) begin
      aw_d[j / BPS][j * BLK +: BLK] = bsum[j];
    end
  end

  assign ovf_d = ctop[NBLK-1] ^ c_d[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        aw_q[k]  <= '0;
        b_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vld_s[k];
          aw_q[k]  <= aw_d[k];
          b_q[k]   <= b_s[k];
          c_q[k]   <= c_d[k];
        end
      end
      if (rdy[STAGES-1]) ovf_q <= ovf_d;
    end
  end

  assign bus.in_ready  = rdy[0] & ~rst;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = aw_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: directed vectors and stall/reset sequences on the default
// configuration, then random traffic on 32/4/2, 16/4/4 and 32/4/1 against an arithmetic model.
module tb_csa_pipe_adder;

  localparam int ND = 3;
  localparam int N_RAND = 10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_v [ND], b_v [ND], sum_v [ND];
  logic        iv_v [ND], cin_v [ND], sub_v [ND], or_v [ND];
  logic        ir_v [ND], ov_v [ND], co_v [ND], of_v [ND];

  csa_pipe_adder_if #(.WIDTH(32)) bus0 ();
  csa_pipe_adder_if #(.WIDTH(16)) bus1 ();
  csa_pipe_adder_if #(.WIDTH(32)) bus2 ();

  csa_pipe_adder #(.WIDTH(32), .BLK(4), .STAGES(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  csa_pipe_adder #(.WIDTH(16), .BLK(4), .STAGES(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  csa_pipe_adder #(.WIDTH(32), .BLK(4), .STAGES(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.in_valid = iv_v[0];  assign bus0.a = a_v[0];  assign bus0.b = b_v[0];
  assign bus0.cin = cin_v[0];      assign bus0.sub = sub_v[0]; assign bus0.out_ready = or_v[0];
  assign ir_v[0] = bus0.in_ready;  assign ov_v[0] = bus0.out_valid; assign sum_v[0] = bus0.sum;
  assign co_v[0] = bus0.cout;      assign of_v[0] = bus0.ovf;

  assign bus1.in_valid = iv_v[1];  assign bus1.a = a_v[1][15:0]; assign bus1.b = b_v[1][15:0];
  assign bus1.cin = cin_v[1];      assign bus1.sub = sub_v[1]; assign bus1.out_ready = or_v[1];
  assign ir_v[1] = bus1.in_ready;  assign ov_v[1] = bus1.out_valid; assign sum_v[1] = {16'h0, bus1.sum};
  assign co_v[1] = bus1.cout;      assign of_v[1] = bus1.ovf;

  assign bus2.in_valid = iv_v[2];  assign bus2.a = a_v[2];  assign bus2.b = b_v[2];
  assign bus2.cin = cin_v[2];      assign bus2.sub = sub_v[2]; assign bus2.out_ready = or_v[2];
  assign ir_v[2] = bus2.in_ready;  assign ov_v[2] = bus2.out_valid; assign sum_v[2] = bus2.sum;
  assign co_v[2] = bus2.cout;      assign of_v[2] = bus2.ovf;

  int n_pass = 0;
  int n_total = 0;

  logic [33:0] fifo [ND][16];
  int unsigned hd [ND], tl [ND], acc_cnt [ND], out_cnt [ND];
  bit          pend [ND], stall_prev [ND];
  logic [33:0] prev_got [ND];

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] sum;
    logic        cout, ovf;
  } vec_t;
  vec_t tbl [7];

  function automatic int unsigned wd(input int d);
    return (d == 1) ? 16 : 32;
  endfunction

  function automatic int unsigned sd(input int d);
    return (d == 0) ? 2 : (d == 1) ? 4 : 1;
  endfunction

  // Signed/unsigned arithmetic over the integers, then reduced to WIDTH bits
  function automatic logic [33:0] model(input int d, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint full, half, ua, ub, sa, sb, us, ss;
    logic co, ov;
    logic [31:0] s;
    full = longint'(1) << wd(d);
    half = full / 2;
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    if (sub) begin
      us = ua - ub - longint'(cin);
      ss = sa - sb - longint'(cin);
      co = (us >= 0);
    end else begin
      us = ua + ub + longint'(cin);
      ss = sa + sb + longint'(cin);
      co = (us >= full);
    end
    ov = (ss < -half) || (ss >= half);
    s  = 32'(us & (full - 1));
    return {ov, co, s};
  endfunction

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] rnd_opnd(input int d);
    logic [31:0] mask;
    mask = (d == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    case ($urandom_range(0, 7))
      0:       return mask;
      1:       return 32'h0;
      2:       return mask ^ (mask >> 1);
      3:       return mask >> 1;
      default: return $urandom & mask;
    endcase
  endfunction

  task automatic clear_model();
    for (int d = 0; d < ND; d++) begin
      hd[d] = 0; tl[d] = 0; acc_cnt[d] = 0; out_cnt[d] = 0;
      pend[d] = 1'b0; stall_prev[d] = 1'b0; prev_got[d] = '0;
    end
  endtask

  task automatic drive(input int d, input bit want, input bit ordy);
    if (!pend[d] && want) begin
      a_v[d]   = rnd_opnd(d);
      b_v[d]   = rnd_opnd(d);
      cin_v[d] = 1'($urandom_range(0, 1));
      sub_v[d] = 1'($urandom_range(0, 1));
      pend[d]  = 1'b1;
    end
    iv_v[d] = pend[d];
    or_v[d] = ordy;
  endtask

  task automatic observe(input int d);
    int unsigned occ;
    logic [33:0] got;
    occ = tl[d] - hd[d];
    got = {of_v[d], co_v[d], sum_v[d]};
    check($sformatf("in_ready_d%0d", d), ir_v[d], (occ < sd(d)) || or_v[d]);
    if (stall_prev[d]) begin
      check($sformatf("hold_valid_d%0d", d), ov_v[d], 1);
      check($sformatf("hold_data_d%0d", d), got, prev_got[d]);
    end
    if (ov_v[d]) begin
      if (occ == 0) check($sformatf("spurious_valid_d%0d", d), ov_v[d], 0);
      else if (or_v[d]) begin
        check($sformatf("result_d%0d", d), got, fifo[d][hd[d] % 16]);
        hd[d]++;
        out_cnt[d]++;
      end
    end
    if (iv_v[d] && ir_v[d]) begin
      fifo[d][tl[d] % 16] = model(d, a_v[d], b_v[d], cin_v[d], sub_v[d]);
      tl[d]++;
      acc_cnt[d]++;
      pend[d] = 1'b0;
    end
    stall_prev[d] = ov_v[d] && !or_v[d];
    prev_got[d]   = got;
  endtask

  initial begin
    int lat;
    int cyc;
    bit saw_drop;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    tbl[5] = '{32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    for (int d = 0; d < ND; d++) begin
      iv_v[d] = 1'b0; or_v[d] = 1'b1; a_v[d] = '0; b_v[d] = '0; cin_v[d] = 1'b0; sub_v[d] = 1'b0;
    end
    clear_model();

    // Reset: outputs cleared, in_ready held low even with a pending request
    @(negedge clk);
    iv_v[0] = 1'b1; a_v[0] = 32'h1234_5678; b_v[0] = 32'h1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_in_ready", ir_v[0], 0);
    check("rst_out_valid", ov_v[0], 0);
    check("rst_sum", sum_v[0], 0);
    check("rst_cout", co_v[0], 0);
    check("rst_ovf", of_v[0], 0);
    check("rst_out_valid_d1", ov_v[1], 0);
    check("rst_out_valid_d2", ov_v[2], 0);
    @(negedge clk);
    iv_v[0] = 1'b0; rst = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) check($sformatf("rel_in_ready_d%0d", d), ir_v[d], 1);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a_v[0] = tbl[i].a; b_v[0] = tbl[i].b; cin_v[0] = tbl[i].cin; sub_v[0] = tbl[i].sub;
      iv_v[0] = 1'b1; or_v[0] = 1'b1;
      #1 check($sformatf("vec%0d_in_ready", i), ir_v[0], 1);
      @(posedge clk); #1;
      iv_v[0] = 1'b0;
      lat = 0;
      while (!ov_v[0] && lat < 10) begin
        @(negedge clk); #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_sum", i), sum_v[0], tbl[i].sum);
      check($sformatf("vec%0d_cout", i), co_v[0], tbl[i].cout);
      check($sformatf("vec%0d_ovf", i), of_v[0], tbl[i].ovf);
    end

    // Back-pressure: six back-to-back operations, sink stalls for four cycles
    @(negedge clk);
    iv_v[0] = 1'b0; or_v[0] = 1'b1;
    @(negedge clk);
    clear_model();
    saw_drop = 1'b0;
    cyc = 0;
    while (out_cnt[0] < 6 && cyc < 40) begin
      @(negedge clk);
      drive(0, acc_cnt[0] < 6, !(cyc >= 3 && cyc < 7));
      #1;
      if (!ir_v[0] && iv_v[0]) saw_drop = 1'b1;
      observe(0);
      cyc++;
    end
    check("bp_in_ready_dropped", saw_drop, 1);
    check("bp_results_out", out_cnt[0], 6);

    // Reset with two operations in flight
    @(negedge clk);
    iv_v[0] = 1'b0;
    clear_model();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(0, 1'b1, 1'b0);
      #1 observe(0);
    end
    check("inflight_accepts", acc_cnt[0], 2);
    @(negedge clk);
    iv_v[0] = 1'b0; or_v[0] = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", ov_v[0], 0);
    check("mid_rst_sum", sum_v[0], 0);
    check("mid_rst_in_ready", ir_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("mid_rel_in_ready", ir_v[0], 1);
    clear_model();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b1);
      #1;
      check("no_stale_result", ov_v[0], 0);
      observe(0);
    end

    // Random traffic on all three configurations in parallel
    clear_model();
    cyc = 0;
    while ((acc_cnt[0] < N_RAND || acc_cnt[1] < N_RAND || acc_cnt[2] < N_RAND) && cyc < 60000) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) drive(d, acc_cnt[d] < N_RAND, $urandom_range(0, 3) != 0);
      #1;
      for (int d = 0; d < ND; d++) observe(d);
      cyc++;
    end
    check("random_within_budget", cyc < 60000, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) drive(d, 1'b0, 1'b1);
      #1;
      for (int d = 0; d < ND; d++) observe(d);
    end
    for (int d = 0; d < ND; d++) begin
      check($sformatf("drained_d%0d", d), tl[d] - hd[d], 0);
      check($sformatf("out_count_d%0d", d), out_cnt[d], acc_cnt[d]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
